// File: rtl/microcode_sequencer.sv
// Top-level control FSM: fetch, decode strobe, microcode latch, stepped execute,
// optional data-memory wait, retire/PC update, halt and sticky trap.
module microcode_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               fetch_req,
  output logic [31:0]        fetch_addr,
  input  logic               fetch_ack,
  input  logic [31:0]        fetch_data,
  output logic [31:0]        instruction,
  output logic               decoder_enable,
  input  logic [31:0]        microcode,
  output logic               exec_enable,
  output logic [STEP_W-1:0]  exec_step,
  output logic               mem_req,
  input  logic               mem_done,
  input  logic               pc_load,
  input  logic [31:0]        pc_target,
  output logic               retire,
  output logic [COUNT_W-1:0] instret,
  input  logic               halt_req,
  output logic               halted,
  output logic               trap,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_LATCH   = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_RETIRE  = 3'd5,
    S_HALTED  = 3'd6,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t              cur_state;
  state_t              nxt_state;
  logic [31:0]         pc;
  logic [31:0]         instr_q;
  logic [STEP_W-1:0]   mc_steps_q;
  logic                mc_mem_q;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   last_step;
  logic [COUNT_W-1:0]  instret_q;
  logic                redirect_pending;
  logic [31:0]         redirect_target;
  logic                bad_redirect;

  // A step count of zero still executes once.
  assign last_step    = (mc_steps_q == '0) ? '0 : mc_steps_q - STEP_ONE;
  assign bad_redirect = redirect_pending && (redirect_target[1:0] != 2'b00);

  assign fetch_addr  = pc;
  assign instruction = instr_q;
  assign instret     = instret_q;
  assign state       = cur_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH:   if (fetch_ack) nxt_state = S_DECODE;
      S_DECODE:  nxt_state = S_LATCH;
      S_LATCH:   nxt_state = (microcode == 32'h0) ? S_TRAP : S_EXECUTE;
      S_EXECUTE: if (step_q == last_step) nxt_state = mc_mem_q ? S_MEM : S_RETIRE;
      S_MEM:     if (mem_done) nxt_state = S_RETIRE;
      S_RETIRE: begin
        if (bad_redirect)  nxt_state = S_TRAP;
        else if (halt_req) nxt_state = S_HALTED;
        else               nxt_state = S_FETCH;
      end
      S_HALTED:  if (!halt_req) nxt_state = S_FETCH;
      S_TRAP:    nxt_state = S_TRAP;
      default:   nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    fetch_req      = 1'b0;
    decoder_enable = 1'b0;
    exec_enable    = 1'b0;
    exec_step      = '0;
    mem_req        = 1'b0;
    retire         = 1'b0;
    halted         = 1'b0;
    trap           = 1'b0;
    case (cur_state)
      S_FETCH:   fetch_req      = 1'b1;
      S_DECODE:  decoder_enable = 1'b1;
      S_EXECUTE: begin
        exec_enable = 1'b1;
        exec_step   = step_q;
      end
      S_MEM:     mem_req = 1'b1;
      S_RETIRE:  retire  = !bad_redirect;
      S_HALTED:  halted  = 1'b1;
      S_TRAP:    trap    = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc               <= RESET_PC;
      instr_q          <= '0;
      mc_steps_q       <= '0;
      mc_mem_q         <= 1'b0;
      step_q           <= '0;
      instret_q        <= '0;
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
    end else begin
      case (cur_state)
        S_FETCH: if (fetch_ack) instr_q <= fetch_data;
        S_LATCH: begin
          mc_steps_q <= microcode[STEP_W-1:0];
          mc_mem_q   <= microcode[4];
          step_q     <= '0;
        end
        S_EXECUTE: step_q <= step_q + STEP_ONE;
        S_RETIRE: begin
          if (!bad_redirect) begin
            pc               <= redirect_pending ? redirect_target : pc + 32'd4;
            instret_q        <= instret_q + COUNT_ONE;
            redirect_pending <= 1'b0;
          end
        end
        default: ;
      endcase
      // Redirects may arrive in any execute or memory-wait cycle; the latest one wins.
      if ((cur_state == S_EXECUTE || cur_state == S_MEM) && pc_load) begin
        redirect_pending <= 1'b1;
        redirect_target  <= pc_target;
      end
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench: builds per-instruction timelines (inputs + expected outputs) from the
// sequencing rules, replays them cycle by cycle and compares every cycle.
module tb_microcode_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int STEP_W  = 4;
  localparam int COUNT_W = 32;
  localparam int VW      = 10 + STEP_W + 64 + COUNT_W;
  localparam int MAXC    = 8192;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_LATCH = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_RETIRE = 3'd5, S_HALT = 3'd6, S_TRAP = 3'd7;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               fetch_req;
  logic [31:0]        fetch_addr;
  logic               fetch_ack;
  logic [31:0]        fetch_data;
  logic [31:0]        instruction;
  logic               decoder_enable;
  logic [31:0]        microcode;
  logic               exec_enable;
  logic [STEP_W-1:0]  exec_step;
  logic               mem_req;
  logic               mem_done;
  logic               pc_load;
  logic [31:0]        pc_target;
  logic               retire;
  logic [COUNT_W-1:0] instret;
  logic               halt_req;
  logic               halted;
  logic               trap;
  logic [2:0]         state;

  always #5 clk = ~clk;

  microcode_sequencer #(.RESET_PC(RESET_PC), .STEP_W(STEP_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .instruction(instruction), .decoder_enable(decoder_enable), .microcode(microcode),
    .exec_enable(exec_enable), .exec_step(exec_step), .mem_req(mem_req), .mem_done(mem_done),
    .pc_load(pc_load), .pc_target(pc_target), .retire(retire), .instret(instret),
    .halt_req(halt_req), .halted(halted), .trap(trap), .state(state)
  );

  typedef struct {
    logic        reset_n;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic [31:0] microcode;
    logic        mem_done;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        halt_req;
  } in_t;

  typedef struct {
    bit                 chk;
    logic [2:0]         st;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic [STEP_W-1:0]  step;
    logic               ret;
    logic [COUNT_W-1:0] icnt;
  } exp_t;

  in_t  in_q[$];
  exp_t exp_q[$];

  logic [31:0]        m_pc;
  logic [31:0]        m_instr;
  logic [COUNT_W-1:0] m_instret;

  int vectors     = 0;
  int miscompares = 0;
  int cur_idx     = -1;

  logic [2:0]  dut_st  [MAXC];
  logic [31:0] dut_addr[MAXC];
  logic        dut_ret [MAXC];
  logic        dut_mreq[MAXC];

  int a1, a2, a3, a4, a5, a6, a7, a8;

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic in_t rnd_in();
    in_t x;
    x.reset_n    = 1'b1;
    x.fetch_ack  = 1'($urandom);
    x.fetch_data = $urandom;
    x.microcode  = $urandom;
    x.mem_done   = 1'($urandom);
    x.pc_load    = 1'($urandom);
    x.pc_target  = $urandom;
    x.halt_req   = 1'($urandom);
    return x;
  endfunction

  task automatic push(input in_t x, input logic [2:0] st, input logic [STEP_W-1:0] step,
                      input logic ret, input bit chk);
    exp_t e;
    e.chk = chk; e.st = st; e.pc = m_pc; e.instr = m_instr;
    e.step = step; e.ret = ret; e.icnt = m_instret;
    in_q.push_back(x);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 32'h0; m_instret = '0;
  endtask

  task automatic trap_tail();
    in_t x;
    int n;
    n = 2 + $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      x = rnd_in();
      push(x, S_TRAP, '0, 1'b0, 1'b1);
    end
    x = rnd_in();
    x.reset_n = 1'b0;
    push(x, S_TRAP, '0, 1'b0, 1'b1);
    model_reset();
  endtask

  task automatic set_load(inout in_t x, input int k, input bit rnd, input int l0_i,
                          input logic [31:0] l0_t, input int l1_i, input logic [31:0] l1_t);
    if (rnd) begin
      x.pc_load   = ($urandom_range(0, 3) == 0);
      x.pc_target = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    end else begin
      x.pc_load = (k == l0_i) || (k == l1_i);
      if (k == l0_i)      x.pc_target = l0_t;
      else if (k == l1_i) x.pc_target = l1_t;
    end
  endtask

  // One instruction's cycle timeline; abort_at injects a reset in that MEM cycle.
  task automatic run_instr(input int ack_d, input logic [31:0] data, input logic [31:0] mc,
                           input int mem_d, input int halt_k, input int abort_at, input bit rnd_ld,
                           input int l0_i, input logic [31:0] l0_t,
                           input int l1_i, input logic [31:0] l1_t);
    in_t x;
    int n, k;
    bit redir;
    logic [31:0] tgt;
    for (int i = 0; i <= ack_d; i++) begin
      x = rnd_in();
      x.fetch_ack = (i == ack_d);
      if (i == ack_d) x.fetch_data = data;
      push(x, S_FETCH, '0, 1'b0, 1'b1);
    end
    m_instr = data;
    x = rnd_in();
    push(x, S_DECODE, '0, 1'b0, 1'b1);
    x = rnd_in();
    x.microcode = mc;
    push(x, S_LATCH, '0, 1'b0, 1'b1);
    if (mc == 32'h0) begin
      trap_tail();
      return;
    end
    n = (mc[3:0] == 4'h0) ? 1 : int'(mc[3:0]);
    redir = 1'b0; tgt = 32'h0; k = 0;
    for (int i = 0; i < n; i++) begin
      x = rnd_in();
      set_load(x, k, rnd_ld, l0_i, l0_t, l1_i, l1_t);
      if (halt_k >= 0) x.halt_req = 1'b1;
      push(x, S_EXEC, STEP_W'(i), 1'b0, 1'b1);
      if (x.pc_load) begin redir = 1'b1; tgt = x.pc_target; end
      k++;
    end
    if (mc[4]) begin
      for (int i = 0; i <= mem_d; i++) begin
        x = rnd_in();
        x.mem_done = (i == mem_d);
        set_load(x, k, rnd_ld, l0_i, l0_t, l1_i, l1_t);
        if (i == abort_at) begin
          x.reset_n = 1'b0;
          push(x, S_MEM, '0, 1'b0, 1'b1);
          model_reset();
          return;
        end
        push(x, S_MEM, '0, 1'b0, 1'b1);
        if (x.pc_load) begin redir = 1'b1; tgt = x.pc_target; end
        k++;
      end
    end
    x = rnd_in();
    x.halt_req = (halt_k >= 0);
    if (redir && tgt[1:0] != 2'b00) begin
      push(x, S_RETIRE, '0, 1'b0, 1'b1);
      trap_tail();
      return;
    end
    push(x, S_RETIRE, '0, 1'b1, 1'b1);
    m_pc = redir ? tgt : m_pc + 32'd4;
    m_instret = m_instret + 1;
    if (halt_k >= 0) begin
      for (int i = 0; i < halt_k; i++) begin
        x = rnd_in();
        x.halt_req = 1'b1;
        push(x, S_HALT, '0, 1'b0, 1'b1);
      end
      x = rnd_in();
      x.halt_req = 1'b0;
      push(x, S_HALT, '0, 1'b0, 1'b1);
    end
  endtask

  task automatic build();
    in_t x;
    logic [31:0] mc;
    int ack_d, mem_d, halt_k, abort_at;
    model_reset();
    x = rnd_in(); x.reset_n = 1'b0;
    push(x, S_FETCH, '0, 1'b0, 1'b0);
    x = rnd_in(); x.reset_n = 1'b0;
    push(x, S_FETCH, '0, 1'b0, 1'b1);

    a1 = in_q.size();
    run_instr(0, 32'h0050_0093, 32'h0000_0001, 0, -1, -1, 1'b0, -1, 32'h0, -1, 32'h0);
    lit("model_pc_after_first", m_pc, 32'h4);
    lit("model_instret_after_first", m_instret, 32'h1);
    a2 = in_q.size();
    run_instr(0, $urandom, 32'h0000_0013, 3, -1, -1, 1'b0, -1, 32'h0, -1, 32'h0);
    lit("model_pc_after_mem", m_pc, 32'h8);
    a3 = in_q.size();
    run_instr(0, $urandom, 32'h0000_0003, 0, -1, -1, 1'b0, 0, 32'h100, 1, 32'h200);
    a4 = in_q.size();
    run_instr(1, $urandom, 32'h0000_0002, 0, 3, -1, 1'b0, -1, 32'h0, -1, 32'h0);
    a5 = in_q.size();
    run_instr(0, $urandom, 32'h0000_0000, 0, -1, -1, 1'b0, -1, 32'h0, -1, 32'h0);
    a6 = in_q.size();
    run_instr(0, $urandom, 32'h0000_0001, 0, -1, -1, 1'b0, 0, 32'h102, -1, 32'h0);
    a7 = in_q.size();
    run_instr(0, $urandom, 32'h0000_0011, 5, -1, 2, 1'b0, -1, 32'h0, -1, 32'h0);
    a8 = in_q.size();
    run_instr(0, $urandom, 32'h0000_0001, 0, -1, -1, 1'b0, 0, 32'hFFFF_FFFC, -1, 32'h0);
    run_instr(0, $urandom, 32'h0000_0001, 0, -1, -1, 1'b0, -1, 32'h0, -1, 32'h0);
    lit("model_pc_wrap", m_pc, 32'h0);

    while (in_q.size() < MAXC - 200) begin
      mc = $urandom;
      if ($urandom_range(0, 29) == 0) mc = 32'h0;
      else if (mc == 32'h0)           mc = 32'h1;
      ack_d    = $urandom_range(0, 3);
      mem_d    = $urandom_range(0, 4);
      halt_k   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      abort_at = (mc[4] && $urandom_range(0, 19) == 0) ? int'($urandom_range(0, mem_d)) : -1;
      run_instr(ack_d, $urandom, mc, mem_d, halt_k, abort_at, 1'b1, -1, 32'h0, -1, 32'h0);
      if (in_q.size() > 3000) break;
    end
  endtask

  always @(negedge clk) begin
    if (cur_idx >= 0 && cur_idx < MAXC) begin
      exp_t e;
      logic [VW-1:0] act, req;
      e = exp_q[cur_idx];
      dut_st[cur_idx]   = state;
      dut_addr[cur_idx] = fetch_addr;
      dut_ret[cur_idx]  = retire;
      dut_mreq[cur_idx] = mem_req;
      if (e.chk) begin
        act = {state, fetch_req, decoder_enable, exec_enable, mem_req, retire, halted, trap,
               exec_step, fetch_addr, instruction, instret};
        req = {e.st, e.st == S_FETCH, e.st == S_DECODE, e.st == S_EXEC, e.st == S_MEM, e.ret,
               e.st == S_HALT, e.st == S_TRAP, e.step, e.pc, e.instr, e.icnt};
        vectors++;
        if (act !== req) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: state %0d/%0d fetch_addr %h/%h instr %h/%h instret %0d/%0d retire %b/%b exec_step %0d/%0d raw %h/%h (got/required)",
                   cur_idx, state, e.st, fetch_addr, e.pc, instruction, e.instr, instret, e.icnt,
                   retire, e.ret, exec_step, e.step, act, req);
        end
      end
    end
  end

  initial begin
    int first_ret, mcnt, hcnt, rcnt;
    reset_n = 1'b0; fetch_ack = 1'b0; fetch_data = 32'h0; microcode = 32'h0;
    mem_done = 1'b0; pc_load = 1'b0; pc_target = 32'h0; halt_req = 1'b0;
    build();
    for (int i = 0; i < in_q.size(); i++) begin
      @(posedge clk);
      #1;
      reset_n    = in_q[i].reset_n;
      fetch_ack  = in_q[i].fetch_ack;
      fetch_data = in_q[i].fetch_data;
      microcode  = in_q[i].microcode;
      mem_done   = in_q[i].mem_done;
      pc_load    = in_q[i].pc_load;
      pc_target  = in_q[i].pc_target;
      halt_req   = in_q[i].halt_req;
      cur_idx    = i;
    end
    @(posedge clk);
    #1;
    cur_idx = -1;

    first_ret = -1;
    for (int j = a1; j < a2; j++) if (dut_ret[j] === 1'b1 && first_ret < 0) first_ret = j - a1;
    lit("first_fetch_addr", dut_addr[a1], 32'h0);
    lit("first_retire_offset", 32'(first_ret), 32'd4);

    mcnt = 0; first_ret = -1;
    for (int j = a2; j < a3; j++) begin
      if (dut_mreq[j] === 1'b1) mcnt++;
      if (dut_ret[j] === 1'b1 && first_ret < 0) first_ret = j - a2;
    end
    lit("mem_req_cycles", 32'(mcnt), 32'd4);
    lit("mem_retire_offset", 32'(first_ret), 32'd10);
    lit("fetch_after_mem", dut_addr[a3], 32'h8);
    lit("fetch_after_redirect", dut_addr[a4], 32'h200);

    hcnt = 0;
    for (int j = a4; j < a5; j++) if (dut_st[j] === S_HALT) hcnt++;
    lit("halted_cycles", 32'(hcnt), 32'd4);
    lit("fetch_after_halt", dut_addr[a5], 32'h204);

    rcnt = 0;
    for (int j = a5; j < a6; j++) if (dut_ret[j] === 1'b1) rcnt++;
    lit("illegal_op_state", 32'(dut_st[a5 + 3]), 32'd7);
    lit("illegal_op_retires", 32'(rcnt), 32'd0);
    lit("post_trap_reset_pc", dut_addr[a6], RESET_PC);

    rcnt = 0;
    for (int j = a6; j < a7; j++) if (dut_ret[j] === 1'b1) rcnt++;
    lit("misaligned_trap_state", 32'(dut_st[a6 + 5]), 32'd7);
    lit("misaligned_retires", 32'(rcnt), 32'd0);

    lit("mem_before_abort", 32'(dut_mreq[a7 + 6]), 32'd1);
    lit("mem_after_abort", 32'(dut_mreq[a8]), 32'd0);
    lit("state_after_abort", 32'(dut_st[a8]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
